// File: rtl/stream_cipher_ctrl_pkg.sv
// rtl/stream_cipher_ctrl_pkg.sv - shared types, tap masks and keystream helpers
package stream_cipher_ctrl_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps: s1 bits 6,5,4,0; s2 bits 7,2,1,0; s3 bits 4,3,1,0
    localparam logic [LFSR_W-1:0] TAPS1 = 8'h71;
    localparam logic [LFSR_W-1:0] TAPS2 = 8'h87;
    localparam logic [LFSR_W-1:0] TAPS3 = 8'h1B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_READY,
        ST_GEN,
        ST_OUT
    } state_t;

    function automatic logic combine(input logic a, input logic b, input logic c);
        return (a & b) ^ c;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] taps);
        return {^(s & taps), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr3_core.sv
// rtl/lfsr3_core.sv - three 8-bit LFSRs with nonlinear combiner
module lfsr3_core
    import stream_cipher_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] key1,
    input  logic [LFSR_W-1:0] key2,
    input  logic [LFSR_W-1:0] key3,
    output logic              ks_bit,
    output logic [LFSR_W-1:0] s1,
    output logic [LFSR_W-1:0] s2,
    output logic [LFSR_W-1:0] s3
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else if (load) begin
            s1 <= key1;
            s2 <= key2;
            s3 <= key3;
        end else if (step) begin
            s1 <= lfsr_next(s1, TAPS1);
            s2 <= lfsr_next(s2, TAPS2);
            s3 <= lfsr_next(s3, TAPS3);
        end
    end

    assign ks_bit = combine(s1[LFSR_W-1], s2[LFSR_W-1], s3[LFSR_W-1]);

endmodule

// File: rtl/stream_cipher_ctrl.sv
// rtl/stream_cipher_ctrl.sv - key load, warm-up and byte-wise XOR sequencing
module stream_cipher_ctrl
    import stream_cipher_ctrl_pkg::*;
#(
    parameter int WARMUP_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [7:0]       key1,
    input  logic [7:0]       key2,
    input  logic [7:0]       key3,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             ks_ready,
    output logic             key_err,
    output logic [CNT_W-1:0] byte_count
);

    localparam int WC_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

    state_t          state;
    state_t          state_nx;
    logic [WC_W-1:0] wcnt;
    logic [2:0]      bcnt;
    logic [7:0]      data_lat;
    logic [7:0]      ks_byte;
    logic            step;
    logic            key_bad;
    logic            ks_bit;
    logic [7:0]      ld1;
    logic [7:0]      ld2;
    logic [7:0]      ld3;
    logic [7:0]      unused_s1;
    logic [7:0]      unused_s2;
    logic [7:0]      unused_s3;

    // A rejected key set still loads, but with zeros so the LFSRs are cleared
    assign key_bad = (key1 == 8'h00) | (key2 == 8'h00) | (key3 == 8'h00);
    assign ld1     = key_bad ? 8'h00 : key1;
    assign ld2     = key_bad ? 8'h00 : key2;
    assign ld3     = key_bad ? 8'h00 : key3;

    lfsr3_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (key_load),
        .step   (step),
        .key1   (ld1),
        .key2   (ld2),
        .key3   (ld3),
        .ks_bit (ks_bit),
        .s1     (unused_s1),
        .s2     (unused_s2),
        .s3     (unused_s3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step     = 1'b0;
        if (key_load) begin
            if (key_bad) begin
                state_nx = ST_IDLE;
            end else if (WARMUP_CYCLES == 0) begin
                state_nx = ST_READY;
            end else begin
                state_nx = ST_WARMUP;
            end
        end else begin
            case (state)
                ST_WARMUP: begin
                    step = 1'b1;
                    if (wcnt == WC_LAST) state_nx = ST_READY;
                end
                ST_READY: begin
                    if (in_valid) state_nx = ST_GEN;
                end
                ST_GEN: begin
                    step = 1'b1;
                    if (bcnt == 3'd7) state_nx = ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) state_nx = ST_READY;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt       <= '0;
            bcnt       <= '0;
            data_lat   <= '0;
            ks_byte    <= '0;
            out_data   <= '0;
            byte_count <= '0;
            key_err    <= 1'b0;
        end else if (key_load) begin
            key_err <= key_bad;
            wcnt    <= '0;
            if (!key_bad) byte_count <= '0;
        end else begin
            case (state)
                ST_WARMUP: wcnt <= wcnt + 1'b1;
                ST_READY: begin
                    if (in_valid) begin
                        data_lat <= in_data;
                        bcnt     <= '0;
                    end
                end
                ST_GEN: begin
                    // First generated bit lands in the MSB
                    ks_byte[3'd7 - bcnt] <= ks_bit;
                    bcnt                 <= bcnt + 1'b1;
                    if (bcnt == 3'd7) out_data <= data_lat ^ {ks_byte[7:1], ks_bit};
                end
                ST_OUT: begin
                    if (out_ready) byte_count <= byte_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_READY);
    assign out_valid = (state == ST_OUT);
    assign ks_ready  = (state == ST_READY) || (state == ST_GEN) || (state == ST_OUT);

endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// tb/tb_stream_cipher_ctrl.sv - randomized self-checking bench for stream_cipher_ctrl
module tb_stream_cipher_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_load = 1'b0;
    logic [7:0] key1 = 8'h00, key2 = 8'h00, key3 = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    logic        a_in_ready, a_out_valid, a_ks_ready, a_key_err;
    logic [7:0]  a_out_data;
    logic [15:0] a_byte_count;
    logic        b_in_ready, b_out_valid, b_ks_ready, b_key_err;
    logic [7:0]  b_out_data;
    logic [15:0] b_byte_count;

    logic        in_ready, out_valid, ks_ready, key_err;
    logic [7:0]  out_data;
    logic [15:0] byte_count;

    int npass = 0;
    int ntotal = 0;

    logic [7:0] m1, m2, m3;

    always #5 clk = ~clk;

    stream_cipher_ctrl #(.WARMUP_CYCLES(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .key_load(key_load),
        .key1(key1), .key2(key2), .key3(key3),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .ks_ready(a_ks_ready), .key_err(a_key_err), .byte_count(a_byte_count)
    );

    stream_cipher_ctrl #(.WARMUP_CYCLES(64), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .key_load(key_load),
        .key1(key1), .key2(key2), .key3(key3),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .ks_ready(b_ks_ready), .key_err(b_key_err), .byte_count(b_byte_count)
    );

    assign in_ready   = sel ? b_in_ready   : a_in_ready;
    assign out_valid  = sel ? b_out_valid  : a_out_valid;
    assign ks_ready   = sel ? b_ks_ready   : a_ks_ready;
    assign key_err    = sel ? b_key_err    : a_key_err;
    assign out_data   = sel ? b_out_data   : a_out_data;
    assign byte_count = sel ? b_byte_count : a_byte_count;

    // Reference keystream: right shift, parity of tapped bits enters the top
    function automatic logic [7:0] adv(input logic [7:0] s, input logic [7:0] taps);
        logic [7:0] r;
        r = s >> 1;
        r[7] = ($countones(s & taps) % 2) == 1;
        return r;
    endfunction

    task automatic model_step();
        m1 = adv(m1, 8'h71);
        m2 = adv(m2, 8'h87);
        m3 = adv(m3, 8'h1B);
    endtask

    task automatic model_load(input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3,
                              input int warm);
        m1 = k1; m2 = k2; m3 = k3;
        repeat (warm) model_step();
    endtask

    task automatic model_ks(output logic [7:0] ks);
        for (int i = 0; i < 8; i++) begin
            ks[7-i] = (m1[7] & m2[7]) ^ m3[7];
            model_step();
        end
    endtask

    task automatic load_keys(input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3);
        @(negedge clk);
        key_load = 1'b1; key1 = k1; key2 = k2; key3 = k3;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Offers one byte, returns result and the cycles from accept to out_valid
    task automatic xfer(input logic [7:0] b, output logic [7:0] got, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        got = out_data;
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ntotal++;
        if ({in_ready, out_valid, ks_ready, key_err} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {in_ready, out_valid, ks_ready, key_err});
        else npass++;
        ntotal++;
        if (out_data !== 8'h00 || byte_count !== 16'd0) $display("FAIL reset_data got %h/%0d want 00/0", out_data, byte_count);
        else npass++;
        rst = 1'b0;
    endtask

    task automatic test_known_vectors();
        logic [7:0] got, ks;
        int lat;
        sel = 1'b0;
        load_keys(8'hFF, 8'hFF, 8'hFF);
        model_load(8'hFF, 8'hFF, 8'hFF, 0);
        ntotal++;
        if (ks_ready !== 1'b1 || in_ready !== 1'b1) $display("FAIL w0_ready got %b%b want 11", ks_ready, in_ready);
        else npass++;
        xfer(8'h00, got, lat);
        model_ks(ks);
        ntotal++;
        if (got !== 8'h04 || got !== ks) $display("FAIL vec_00 got %h want 04 (model %h)", got, ks);
        else npass++;
        ntotal++;
        if (lat !== 8) $display("FAIL latency got %0d want 8", lat);
        else npass++;
        accept_out();
        ntotal++;
        if (in_ready !== 1'b1 || byte_count !== 16'd1) $display("FAIL after_accept got %b/%0d want 1/1", in_ready, byte_count);
        else npass++;
        load_keys(8'hFF, 8'hFF, 8'hFF);
        xfer(8'hA5, got, lat);
        ntotal++;
        if (got !== 8'hA1) $display("FAIL vec_A5 got %h want A1", got);
        else npass++;
        accept_out();
    endtask

    task automatic test_warmup_timing();
        sel = 1'b1;
        load_keys(8'h3C, 8'h5A, 8'h96);
        repeat (63) @(negedge clk);
        ntotal++;
        if (ks_ready !== 1'b0 || in_ready !== 1'b0) $display("FAIL warm_63 got %b%b want 00", ks_ready, in_ready);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (ks_ready !== 1'b1 || in_ready !== 1'b1) $display("FAIL warm_64 got %b%b want 11", ks_ready, in_ready);
        else npass++;
    endtask

    task automatic test_round_trip();
        logic [7:0] plain [16];
        logic [7:0] ciph [16];
        logic [7:0] got, ks;
        int lat, bad;
        sel = 1'b1;
        load_keys(8'h3C, 8'h5A, 8'h96);
        model_load(8'h3C, 8'h5A, 8'h96, 64);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            plain[i] = 8'($urandom);
            xfer(plain[i], got, lat);
            model_ks(ks);
            ciph[i] = got;
            if (got !== (plain[i] ^ ks) || lat != 8) begin
                bad++;
                $display("FAIL encrypt[%0d] got %h lat %0d want %h lat 8", i, got, lat, plain[i] ^ ks);
            end
            accept_out();
        end
        ntotal++;
        if (bad != 0) $display("FAIL encrypt_stream got %0d bad want 0", bad);
        else npass++;
        ntotal++;
        if (byte_count !== 16'd16) $display("FAIL count_enc got %0d want 16", byte_count);
        else npass++;
        load_keys(8'h3C, 8'h5A, 8'h96);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            xfer(ciph[i], got, lat);
            if (got !== plain[i]) begin
                bad++;
                $display("FAIL decrypt[%0d] got %h want %h", i, got, plain[i]);
            end
            accept_out();
        end
        ntotal++;
        if (bad != 0) $display("FAIL decrypt_stream got %0d bad want 0", bad);
        else npass++;
        ntotal++;
        if (byte_count !== 16'd16) $display("FAIL count_dec got %0d want 16", byte_count);
        else npass++;
    endtask

    task automatic test_key_err();
        int seen;
        sel = 1'b1;
        load_keys(8'h3C, 8'h00, 8'h96);
        ntotal++;
        if (key_err !== 1'b1) $display("FAIL key_err_set got %b want 1", key_err);
        else npass++;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (ks_ready || in_ready) seen++;
        end
        ntotal++;
        if (seen != 0) $display("FAIL key_err_idle got %0d ready cycles want 0", seen);
        else npass++;
        load_keys(8'h11, 8'h22, 8'h33);
        model_load(8'h11, 8'h22, 8'h33, 64);
        ntotal++;
        if (key_err !== 1'b0) $display("FAIL key_err_clear got %b want 0", key_err);
        else npass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] got, ks, b;
        int lat, bad;
        sel = 1'b1;
        b = 8'($urandom);
        xfer(b, got, lat);
        model_ks(ks);
        ntotal++;
        if (got !== (b ^ ks)) $display("FAIL bp_first got %h want %h", got, b ^ ks);
        else npass++;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_data !== got || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        ntotal++;
        if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
        else npass++;
        accept_out();
        b = 8'($urandom);
        xfer(b, got, lat);
        model_ks(ks);
        ntotal++;
        if (got !== (b ^ ks)) $display("FAIL bp_next got %h want %h", got, b ^ ks);
        else npass++;
        accept_out();
    endtask

    task automatic test_key_load_abort();
        logic [7:0] got, ks, b;
        int n;
        sel = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_data = 8'h5E;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        key_load = 1'b1; key1 = 8'hC3; key2 = 8'h81; key3 = 8'h7E;
        @(negedge clk);
        key_load = 1'b0;
        ntotal++;
        if (out_valid !== 1'b0 || ks_ready !== 1'b0 || byte_count !== 16'd0) $display("FAIL abort_gen got %b%b/%0d want 00/0", out_valid, ks_ready, byte_count);
        else npass++;
        model_load(8'hC3, 8'h81, 8'h7E, 64);
        b = 8'($urandom);
        xfer(b, got, n);
        model_ks(ks);
        ntotal++;
        if (got !== (b ^ ks) || n != 8) $display("FAIL abort_gen_next got %h lat %0d want %h lat 8", got, n, b ^ ks);
        else npass++;
        accept_out();
        b = 8'($urandom);
        xfer(b, got, n);
        model_ks(ks);
        key_load = 1'b1; key1 = 8'h0F; key2 = 8'hF0; key3 = 8'h55;
        @(negedge clk);
        key_load = 1'b0;
        ntotal++;
        if (out_valid !== 1'b0 || byte_count !== 16'd0) $display("FAIL abort_out got %b/%0d want 0/0", out_valid, byte_count);
        else npass++;
        model_load(8'h0F, 8'hF0, 8'h55, 64);
        b = 8'($urandom);
        xfer(b, got, n);
        model_ks(ks);
        ntotal++;
        if (got !== (b ^ ks)) $display("FAIL abort_out_next got %h want %h", got, b ^ ks);
        else npass++;
        accept_out();
        ntotal++;
        if (byte_count !== 16'd1) $display("FAIL abort_count got %0d want 1", byte_count);
        else npass++;
    endtask

    task automatic test_async_reset();
        int seen;
        sel = 1'b1;
        load_keys(8'h3C, 8'h5A, 8'h96);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        ntotal++;
        if ({in_ready, out_valid, ks_ready, key_err} !== 4'b0000 || out_data !== 8'h00 || byte_count !== 16'd0)
            $display("FAIL async_reset got %b/%h/%0d want 0000/00/0", {in_ready, out_valid, ks_ready, key_err}, out_data, byte_count);
        else npass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (ks_ready || in_ready) seen++;
        end
        ntotal++;
        if (seen != 0) $display("FAIL async_reset_idle got %0d ready cycles want 0", seen);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_warmup_timing();
        test_round_trip();
        test_key_err();
        test_backpressure();
        test_key_load_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
